// File: rtl/int32_to_fp32_seq.sv
// Sequential 32-bit integer to IEEE-754 single-precision converter.
// One operand in flight: capture sign/magnitude, shift left one bit per
// cycle until the leading one reaches bit 31, then pack the truncated result.
module int32_to_fp32_seq #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // 127 bias + 31: exponent of a value whose leading one sits at bit 31.
    localparam logic [7:0] EXP_START = 8'd158;

    logic [1:0]  state_reg, state_next;
    logic [31:0] mag_reg, mag_next;
    logic [7:0]  exp_reg, exp_next;
    logic        sign_reg, sign_next;
    logic [31:0] out_data_reg, out_data_next;

    logic        in_sign;
    logic [31:0] in_mag;

    // Sign only exists for two's-complement operands.
    if (SIGNED_IN) begin : g_signed
        assign in_sign = in_data[31];
    end else begin : g_unsigned
        assign in_sign = 1'b0;
    end

    // Magnitude; 0x80000000 negates to itself, which is the correct magnitude.
    assign in_mag = in_sign ? (~in_data + 32'd1) : in_data;

    // Handshake flags come straight from the state register.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;

    // Next-state and datapath update for the IDLE/NORM/DONE sequence.
    always_comb begin
        state_next    = state_reg;
        mag_next      = mag_reg;
        exp_next      = exp_reg;
        sign_next     = sign_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    exp_next = EXP_START;
                    if (in_mag == 32'd0) begin
                        // Zero has no leading one: emit +0 immediately.
                        sign_next     = 1'b0;
                        mag_next      = 32'd0;
                        out_data_next = 32'h0000_0000;
                        state_next    = DONE;
                    end else begin
                        sign_next  = in_sign;
                        mag_next   = in_mag;
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_reg[31]) begin
                    // Hidden bit dropped, low 8 bits truncated (round toward zero).
                    out_data_next = {sign_reg, exp_reg, mag_reg[30:8]};
                    state_next    = DONE;
                end else begin
                    mag_next = {mag_reg[30:0], 1'b0};
                    exp_next = exp_reg - 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mag_reg      <= 32'd0;
            exp_reg      <= 8'd0;
            sign_reg     <= 1'b0;
            out_data_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            mag_reg      <= mag_next;
            exp_reg      <= exp_next;
            sign_reg     <= sign_next;
            out_data_reg <= out_data_next;
        end
    end

endmodule

// File: doc/int32_to_fp32_seq.md
INT32_TO_FP32_SEQ -- requirements
Module: int32_to_fp32_seq

Interface
REQ-001 The block SHALL have parameter SIGNED_IN, default 1, meaning in_data is two's-complement when 1 and unsigned when 0.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-005 Port in_valid, input, 1 bit: in_data holds a valid operand.
REQ-006 Port in_ready, output, 1 bit: block can accept an operand this cycle.
REQ-007 Port in_data, input, 32 bits: integer operand.
REQ-008 Port out_valid, output, 1 bit: out_data holds a valid FP32 result.
REQ-009 Port out_ready, input, 1 bit: consumer accepts the result this cycle.
REQ-010 Port out_data, output, 32 bits: IEEE-754 single-precision result {sign, exp[7:0], frac[22:0]}.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, NORM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be driven directly from the state register.
REQ-013 An accept edge is any rising edge with in_valid=1 and in_ready=1; in_valid in any state other than IDLE SHALL be ignored.
REQ-014 On accept, sign SHALL be captured as in_data[31] when SIGNED_IN=1 and as 0 otherwise.
REQ-015 On accept, the 32-bit unsigned magnitude SHALL be captured as the two's-complement negation of in_data when the sign is 1, and as in_data otherwise; 0x80000000 signed SHALL yield magnitude 0x80000000.
REQ-016 On accept, the exponent register SHALL load 158, which is 127+31, as 8 bits.
REQ-017 On accept with magnitude 0, the FSM SHALL go directly to DONE with out_data=0x00000000 (+0, sign forced to 0).
REQ-018 On accept with nonzero magnitude, the FSM SHALL go to NORM.
REQ-019 In NORM, each edge with mag[31]=0 SHALL shift mag left 1 bit and decrement the exponent by 1, with no other action.
REQ-020 In NORM, an edge with mag[31]=1 SHALL load out_data={sign, exp, mag[30:8]} and move the FSM to DONE.
REQ-021 Rounding SHALL be truncation (round toward zero): mag[7:0] is discarded, matching the truncating behaviour of the FP32 adder family.
REQ-022 Latency: with lz = leading zeros of the magnitude, out_valid SHALL rise lz+1 edges after the accept edge (range 1 to 32), and 1 edge after it for zero input.
REQ-023 In DONE, out_data SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 In DONE, an edge with out_ready=1 SHALL return the FSM to IDLE, so in_ready is 1 in the following cycle; there is no accept in the same edge.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 The exponent SHALL never underflow, since the maximum number of shifts is 31, giving a minimum exponent of 127.
REQ-027 The block SHALL hold one operand in flight; a new operand SHALL NOT be accepted before the previous result is consumed.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state=IDLE, out_valid=0, in_ready=1, out_data=0x00000000, and clear the mag, exp and sign registers.
REQ-029 Reset asserted in NORM or DONE SHALL abort the operation without producing any output; the first accept after rst_n deasserts SHALL behave as from power-up.

Verification
REQ-030 SIGNED_IN=1, in_data=0x00000001, out_ready=1 -> out_data=0x3F800000, out_valid 32 edges after accept.
REQ-031 SIGNED_IN=1, in_data=0xFFFFFFFF -> 0xBF800000; in_data=0x80000000 -> 0xCF000000 with out_valid after 1 edge; in_data=0 -> 0x00000000 after 1 edge.
REQ-032 SIGNED_IN=1, in_data=0x7FFFFFFF -> 0x4EFFFFFF (truncated) after 2 edges; in_data=1000 -> 0x447A0000 after 23 edges.
REQ-033 SIGNED_IN=0, in_data=0xFFFFFFFF -> 0x4F7FFFFF after 1 edge; in_data=0x80000000 -> 0x4F000000.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_data -> out_data and out_valid stay constant and in_ready stays 0; the result is consumed on the first edge with out_ready=1 and in_ready is 1 in the next cycle.
REQ-035 Reset mid-NORM: accept 0x00000001, assert rst_n=0 five edges later -> out_valid=0 and in_ready=1 immediately; after release, accept 0x00000002 -> 0x40000000 after 31 edges.
